phase_monitor: RTL and testbench



---
 rtl/phase_monitor_pkg.sv | 19 +
 rtl/hex_to_7seg.sv | 30 +++
 rtl/key_debounce.sv | 42 ++++
 rtl/phase_monitor.sv | 154 +++++++++++++++
 tb/tb_phase_monitor.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/phase_monitor_pkg.sv
// Shared types and constants for the phase-array status display.
package phase_monitor_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        FREEZE = 2'b10,
        ERRCNT = 2'b11
    } mode_e;

    localparam logic [6:0] BLANK_SEG       = 7'h7F;
    localparam int         DIGITS_PER_PAGE = 6;
    localparam int         CH_PER_PAGE     = 3;

    function automatic int num_pages(input int nch);
        return (nch + CH_PER_PAGE - 1) / CH_PER_PAGE;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex_to_7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// Raw active-low key: 2-FF sync, stability filter, one-cycle pulse on accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1, r_s2, r_level, r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_s1    <= i_key_n;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // old level 1 means this acceptance is the 1->0 press edge
                r_level <= r_s2;
                r_cnt   <= '0;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/phase_monitor.sv
// Paged 7-segment phase display with manual/auto/freeze/error-count modes,
// read-error tracking and heartbeat LED.
module phase_monitor
    import phase_monitor_pkg::*;
#(
    parameter int NUM_CHANNELS     = 4,
    parameter int PHASE_W          = 8,
    parameter int DEBOUNCE_CYCLES  = 500_000,
    parameter int SCROLL_CYCLES    = 50_000_000,
    parameter int HEARTBEAT_CYCLES = 16_777_216
) (
    input  logic                                 sys_clk,
    input  logic                                 ext_rst_n,
    input  logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
    input  logic                                 read_error,
    input  logic [1:0]                           mode_sw,
    input  logic                                 step_key_n,
    input  logic                                 clear_key_n,
    output logic [9:0]                           ledr,
    output logic [5:0][6:0]                      hex
);

    localparam int NUM_PAGES = num_pages(NUM_CHANNELS);
    localparam int SCW       = $clog2(SCROLL_CYCLES + 1);
    localparam int HBW       = $clog2(HEARTBEAT_CYCLES + 1);

    logic [1:0]                        r_mode_s1, r_mode_s2;
    mode_e                             r_mode_q, w_mode;
    logic                              w_enter, w_step, w_clear, w_adv;
    logic [7:0]                        r_page, w_page_nxt, r_ledr_page;
    logic [SCW-1:0]                    r_scroll, w_scroll_nxt;
    logic [HBW-1:0]                    r_hb_cnt;
    logic                              r_hb;
    logic                              r_re_d, r_rise, r_err_flag, w_flag_nxt;
    logic [15:0]                       r_err_cnt, w_cnt_nxt;
    logic [NUM_CHANNELS-1:0][7:0]      w_ph, r_snap, w_src;
    logic [9:0]                        w_ch;
    logic [DIGITS_PER_PAGE-1:0][3:0]   w_nib;
    logic [DIGITS_PER_PAGE-1:0]        w_blank;
    logic [DIGITS_PER_PAGE-1:0][6:0]   w_seg, r_hex;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ext
        assign w_ph[c] = 8'(phases[c]);
    end

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .i_clk(sys_clk), .i_rst_n(ext_rst_n), .i_key_n(step_key_n), .o_press(w_step)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .i_clk(sys_clk), .i_rst_n(ext_rst_n), .i_key_n(clear_key_n), .o_press(w_clear)
    );

    always_comb begin
        w_mode  = mode_e'(r_mode_s2);
        w_enter = (w_mode != r_mode_q);

        // scroll timer idles at zero and restarts on every entry into auto
        w_adv        = 1'b0;
        w_scroll_nxt = '0;
        if (w_mode == AUTO && !w_enter) begin
            if (r_scroll == SCW'(SCROLL_CYCLES - 1)) w_adv = 1'b1;
            else                                     w_scroll_nxt = r_scroll + 1'b1;
        end
        if (w_mode == MANUAL && w_step) w_adv = 1'b1;

        w_page_nxt = r_page;
        if (w_adv) w_page_nxt = (r_page == 8'(NUM_PAGES - 1)) ? 8'd0 : r_page + 8'd1;

        w_flag_nxt = r_err_flag;
        w_cnt_nxt  = r_err_cnt;
        if (w_clear) begin
            w_flag_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (r_rise) begin
            w_flag_nxt = 1'b1;
            if (r_err_cnt != 16'hFFFF) w_cnt_nxt = r_err_cnt + 16'd1;
        end

        // freeze entry cycle shows the live value being captured
        w_src = (w_mode == FREEZE && !w_enter) ? r_snap : w_ph;
    end

    always_comb begin
        w_nib   = '0;
        w_blank = '1;
        w_ch    = '0;
        if (w_mode == ERRCNT) begin
            for (int d = 0; d < 4; d++) begin
                w_nib[d]   = w_cnt_nxt[4*d +: 4];
                w_blank[d] = 1'b0;
            end
        end else begin
            for (int i = 0; i < CH_PER_PAGE; i++) begin
                w_ch = {2'b00, w_page_nxt} * 10'(CH_PER_PAGE) + 10'(i);
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    if (w_ch == 10'(c)) begin
                        w_nib[5-2*i]   = w_src[c][7:4];
                        w_nib[4-2*i]   = w_src[c][3:0];
                        w_blank[5-2*i] = 1'b0;
                        w_blank[4-2*i] = 1'b0;
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < DIGITS_PER_PAGE; d++) begin : g_seg
        hex_to_7seg u_seg (.i_hex(w_nib[d]), .o_seg(w_seg[d]));
    end

    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_mode_s1   <= 2'b00;
            r_mode_s2   <= 2'b00;
            r_mode_q    <= MANUAL;
            r_page      <= '0;
            r_scroll    <= '0;
            r_hb_cnt    <= '0;
            r_hb        <= 1'b0;
            r_re_d      <= 1'b0;
            r_rise      <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
            r_snap      <= '0;
            r_ledr_page <= '0;
            r_hex       <= {DIGITS_PER_PAGE{BLANK_SEG}};
        end else begin
            r_mode_s1  <= mode_sw;
            r_mode_s2  <= r_mode_s1;
            r_mode_q   <= w_mode;
            r_page     <= w_page_nxt;
            r_scroll   <= w_scroll_nxt;
            r_re_d     <= read_error;
            r_rise     <= read_error & ~r_re_d;
            r_err_flag <= w_flag_nxt;
            r_err_cnt  <= w_cnt_nxt;
            if (w_mode == FREEZE && w_enter) r_snap <= w_ph;
            if (r_hb_cnt == HBW'(HEARTBEAT_CYCLES - 1)) begin
                r_hb_cnt <= '0;
                r_hb     <= ~r_hb;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
            r_ledr_page <= (w_mode == ERRCNT) ? 8'd0 : w_page_nxt;
            for (int d = 0; d < DIGITS_PER_PAGE; d++)
                r_hex[d] <= w_blank[d] ? BLANK_SEG : w_seg[d];
        end
    end

    assign ledr = {r_hb, r_err_flag, r_ledr_page};
    assign hex  = r_hex;

endmodule

// File: tb/tb_phase_monitor.sv
// Randomised scoreboard bench for phase_monitor; reference model works from
// per-cycle input history and the display/timing rules.
module tb_phase_monitor;

    localparam int NCH = 7, D = 4, S = 16, H = 8, NP = 3, MAXC = 4096;

    typedef struct {
        logic [9:0]      ledr;
        logic [5:0][6:0] hex;
    } exp_t;

    logic                   sys_clk = 1'b0;
    logic                   ext_rst_n;
    logic [NCH-1:0][7:0]    phases;
    logic                   read_error;
    logic [1:0]             mode_sw;
    logic                   step_key_n, clear_key_n;
    logic [9:0]             ledr;
    logic [5:0][6:0]        hex;

    int total = 0, bad = 0, mcyc = 0;
    bit rnd_en = 0;
    int force_req = 0, force_seen = 0;
    exp_t exq[$];

    // model state and input history, indexed by posedge count
    int  n = 8;
    bit [1:0] mode_h[MAXC];
    bit  re_h[MAXC];
    bit  key_h[MAXC] = '{default: 1'b1};
    bit  clr_h[MAXC] = '{default: 1'b1};
    bit  as_h[MAXC]  = '{default: 1'b1};
    bit  ac_h[MAXC]  = '{default: 1'b1};
    int  pg = 0, ent = 0, hbk = 0;
    logic [15:0]         cnt = 0;
    logic                flag = 0;
    logic [NCH-1:0][7:0] snap = '0;

    phase_monitor #(
        .NUM_CHANNELS(NCH), .PHASE_W(8), .DEBOUNCE_CYCLES(D),
        .SCROLL_CYCLES(S), .HEARTBEAT_CYCLES(H)
    ) dut (
        .sys_clk(sys_clk), .ext_rst_n(ext_rst_n), .phases(phases),
        .read_error(read_error), .mode_sw(mode_sw), .step_key_n(step_key_n),
        .clear_key_n(clear_key_n), .ledr(ledr), .hex(hex)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // reference model: one expected output set per clock edge
    always @(posedge sys_clk) begin
        exp_t e;
        int m, mp, ch;
        logic step, clr, rise;
        logic [D-1:0] ws, wc;
        logic [NCH-1:0][7:0] src;
        n++;
        e.ledr = '0;
        e.hex  = {6{7'h7F}};
        if (!ext_rst_n) begin
            mode_h[n] = 0; key_h[n] = 1; clr_h[n] = 1; re_h[n] = 0;
            as_h[n] = 1; ac_h[n] = 1;
            pg = 0; cnt = 0; flag = 0; snap = '0; ent = 0; hbk = 0;
        end else begin
            mode_h[n] = mode_sw; key_h[n] = step_key_n;
            clr_h[n] = clear_key_n; re_h[n] = read_error;
            // a key level is accepted once D synchronised samples agree
            for (int j = 0; j < D; j++) begin
                ws[j] = key_h[n-2-j];
                wc[j] = clr_h[n-2-j];
            end
            as_h[n] = (ws == '0) ? 1'b0 : (ws == '1) ? 1'b1 : as_h[n-1];
            ac_h[n] = (wc == '0) ? 1'b0 : (wc == '1) ? 1'b1 : ac_h[n-1];
            m    = mode_h[n-2];
            mp   = mode_h[n-3];
            step = as_h[n-2] & ~as_h[n-1];
            clr  = ac_h[n-2] & ~ac_h[n-1];
            rise = re_h[n-1] & ~re_h[n-2];
            if (force_seen != force_req) begin
                cnt = 16'hFFFF;
                force_seen = force_req;
            end
            if (clr) begin
                cnt = 0; flag = 0;
            end else if (rise) begin
                flag = 1;
                if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
            end
            if (m == 1) begin
                if (mp != 1) ent = n;
                else if ((n - ent) % S == 0) pg = (pg + 1) % NP;
            end else if (m == 0 && step) begin
                pg = (pg + 1) % NP;
            end
            if (m == 2 && mp != 2) snap = phases;
            hbk++;
            e.ledr[9]   = ((hbk / H) % 2) == 1;
            e.ledr[8]   = flag;
            e.ledr[7:0] = (m == 3) ? 8'h00 : 8'(pg);
            if (m == 3) begin
                for (int d = 0; d < 4; d++) e.hex[d] = seg(cnt[4*d +: 4]);
            end else begin
                src = (m == 2) ? snap : phases;
                for (int i = 0; i < 3; i++) begin
                    ch = 3 * pg + i;
                    if (ch < NCH) begin
                        e.hex[5-2*i] = seg(src[ch[2:0]][7:4]);
                        e.hex[4-2*i] = seg(src[ch[2:0]][3:0]);
                    end
                end
            end
        end
        exq.push_back(e);
    end

    // monitor: compare registered outputs mid-cycle
    always @(negedge sys_clk) begin
        exp_t e;
        if (exq.size() != 0) begin
            e = exq.pop_front();
            mcyc++;
            chk($sformatf("ledr@%0d", mcyc), {54'd0, ledr}, {54'd0, e.ledr});
            chk($sformatf("hex@%0d", mcyc), {22'd0, hex}, {22'd0, e.hex});
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(negedge sys_clk);
            if (rnd_en) for (int c = 1; c < NCH; c++) phases[c] = 8'($urandom);
        end
    endtask

    task automatic press_step(input int lo, input int hi);
        step_key_n = 1'b0; cyc(lo);
        step_key_n = 1'b1; cyc(hi);
    endtask

    task automatic err_pulse();
        read_error = 1'b1; cyc(1);
        read_error = 1'b0; cyc(2);
    endtask

    initial begin
        ext_rst_n = 1'b0; phases = '0; read_error = 1'b0; mode_sw = 2'b00;
        step_key_n = 1'b1; clear_key_n = 1'b1;
        cyc(4);
        ext_rst_n = 1'b1;
        cyc(2);
        phases[0] = 8'h12; phases[1] = 8'h34; phases[2] = 8'h56;
        cyc(5);
        rnd_en = 1;

        // manual stepping, wrap, and a short glitch that must not step
        repeat (3) press_step(8, 8);
        press_step(3, 10);

        // auto scroll with ignored step presses
        mode_sw = 2'b01;
        cyc(10);
        press_step(8, 8);
        cyc(30);
        mode_sw = 2'b00;
        cyc(6);

        // freeze snapshot
        phases[0] = 8'hAB; cyc(2);
        mode_sw = 2'b10;   cyc(6);
        phases[0] = 8'hCD; cyc(6);
        mode_sw = 2'b00;   cyc(6);

        // error tracking, then clear coinciding with a sixth rising edge
        repeat (5) err_pulse();
        mode_sw = 2'b11; cyc(5);
        clear_key_n = 1'b0; cyc(6);
        read_error = 1'b1;  cyc(1);
        read_error = 1'b0;  cyc(8);
        clear_key_n = 1'b1; cyc(10);

        // saturation
        force dut.r_err_cnt = 16'hFFFF;
        force_req++;
        cyc(1);
        release dut.r_err_cnt;
        cyc(2);
        err_pulse();
        cyc(4);

        // randomised mixed activity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) mode_sw = 2'($urandom);
            if ($urandom_range(0, 6) == 0) step_key_n = ~step_key_n;
            if ($urandom_range(0, 9) == 0) clear_key_n = ~clear_key_n;
            read_error = ($urandom_range(0, 3) == 0);
            phases[0]  = 8'($urandom);
            cyc(1);
        end
        read_error = 1'b0; step_key_n = 1'b1; clear_key_n = 1'b1;

        // reset mid-scroll and mid-debounce
        mode_sw = 2'b01;
        cyc(20);
        step_key_n = 1'b0;
        cyc(2);
        #2 ext_rst_n = 1'b0;
        #1;
        chk("async_rst_ledr", {54'd0, ledr}, 64'd0);
        chk("async_rst_hex", {22'd0, hex}, {22'd0, {6{7'h7F}}});
        cyc(3);
        ext_rst_n  = 1'b1;
        step_key_n = 1'b1;
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
